// File: rtl/vend_ctrl_multi.sv
// Vending-machine controller: coin credit accumulation, priced dispense, LED sweep
// for vend/change, cancel refund and inactivity timeout refund.
module vend_ctrl_multi #(
    parameter int TICK_CYCLES   = 50_000_000,
    parameter int PRICE         = 25,
    parameter int COIN_A        = 5,
    parameter int COIN_B        = 10,
    parameter int MAX_CREDIT    = 99,
    parameter int LED_N         = 6,
    parameter int TIMEOUT_TICKS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_a,
    input  logic             coin_b,
    input  logic             cancel,
    output logic [LED_N-1:0] led,
    output logic [3:0]       credit_tens,
    output logic [3:0]       credit_ones,
    output logic             dispense,
    output logic             change_valid,
    output logic [6:0]       change,
    output logic             reject,
    output logic             busy
);

    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = (LED_N > 1) ? $clog2(LED_N) : 1;
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [LED_N-1:0] LED_LSB = LED_N'(1);
    localparam logic [LED_N-1:0] LED_MSB = LED_LSB << (LED_N - 1);

    typedef enum logic [1:0] {IDLE, VEND, CHANGE, REFUND} state_t;

    state_t           state_reg, state_next;
    logic [6:0]       credit_reg, credit_next;
    logic [LED_N-1:0] led_reg, led_next;
    logic [6:0]       change_reg, change_next;
    logic             dispense_reg, dispense_next;
    logic             change_valid_reg, change_valid_next;
    logic             reject_reg, reject_next;
    logic             busy_reg, busy_next;
    logic [TW-1:0]    tick_cnt_reg, tick_cnt_next;
    logic [SW-1:0]    step_reg, step_next;
    logic [OW-1:0]    to_cnt_reg, to_cnt_next;

    logic       tick;
    logic       coin_any;
    logic [7:0] coin_sum;
    logic [7:0] credit_sum;
    logic       sum_fits;
    logic       last_step;
    logic       timeout_en;

    assign tick       = (tick_cnt_reg == TW'(TICK_CYCLES - 1));
    assign coin_any   = coin_a | coin_b;
    assign coin_sum   = (coin_a ? 8'(COIN_A) : 8'd0) + (coin_b ? 8'(COIN_B) : 8'd0);
    assign credit_sum = {1'b0, credit_reg} + coin_sum;
    assign sum_fits   = (credit_sum <= 8'(MAX_CREDIT));
    assign last_step  = (step_reg == SW'(LED_N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            led_reg          <= '0;
            change_reg       <= '0;
            dispense_reg     <= 1'b0;
            change_valid_reg <= 1'b0;
            reject_reg       <= 1'b0;
            busy_reg         <= 1'b0;
            tick_cnt_reg     <= '0;
            step_reg         <= '0;
            to_cnt_reg       <= '0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            led_reg          <= led_next;
            change_reg       <= change_next;
            dispense_reg     <= dispense_next;
            change_valid_reg <= change_valid_next;
            reject_reg       <= reject_next;
            busy_reg         <= busy_next;
            tick_cnt_reg     <= tick_cnt_next;
            step_reg         <= step_next;
            to_cnt_reg       <= to_cnt_next;
        end
    end

    always_comb begin
        state_next        = state_reg;
        credit_next       = credit_reg;
        led_next          = led_reg;
        change_next       = change_reg;
        dispense_next     = 1'b0;
        change_valid_next = 1'b0;
        reject_next       = 1'b0;
        tick_cnt_next     = tick ? '0 : tick_cnt_reg + TW'(1);
        step_next         = step_reg;
        to_cnt_next       = to_cnt_reg;
        timeout_en        = 1'b0;

        case (state_reg)
            IDLE: begin
                // cancel wins over coins; a coin arriving with it is bounced
                if (cancel) begin
                    reject_next = coin_any;
                    if (credit_reg != 7'd0) begin
                        state_next  = REFUND;
                        to_cnt_next = '0;
                    end
                end else if (coin_any && sum_fits) begin
                    credit_next = credit_sum[6:0];
                    to_cnt_next = '0;
                end else if (coin_any) begin
                    reject_next = 1'b1;
                    timeout_en  = 1'b1;
                end else if (credit_reg >= 7'(PRICE)) begin
                    state_next    = VEND;
                    credit_next   = credit_reg - 7'(PRICE);
                    led_next      = LED_LSB;
                    dispense_next = 1'b1;
                    tick_cnt_next = '0;
                    step_next     = '0;
                    to_cnt_next   = '0;
                end else begin
                    timeout_en = 1'b1;
                end

                if (timeout_en) begin
                    if (credit_reg == 7'd0) begin
                        to_cnt_next = '0;
                    end else if (tick) begin
                        if (to_cnt_reg == OW'(TIMEOUT_TICKS - 1)) begin
                            state_next  = REFUND;
                            to_cnt_next = '0;
                        end else begin
                            to_cnt_next = to_cnt_reg + OW'(1);
                        end
                    end
                end
            end

            VEND: begin
                reject_next = coin_any;
                if (tick) begin
                    if (last_step) begin
                        step_next = '0;
                        if (credit_reg != 7'd0) begin
                            state_next = CHANGE;
                            led_next   = LED_MSB;
                        end else begin
                            state_next = IDLE;
                            led_next   = '0;
                        end
                    end else begin
                        led_next  = led_reg << 1;
                        step_next = step_reg + SW'(1);
                    end
                end
            end

            CHANGE: begin
                reject_next = coin_any;
                if (tick) begin
                    if (last_step) begin
                        state_next        = IDLE;
                        led_next          = '0;
                        step_next         = '0;
                        change_next       = credit_reg;
                        credit_next       = 7'd0;
                        change_valid_next = 1'b1;
                    end else begin
                        led_next  = led_reg >> 1;
                        step_next = step_reg + SW'(1);
                    end
                end
            end

            REFUND: begin
                reject_next       = coin_any;
                change_next       = credit_reg;
                credit_next       = 7'd0;
                change_valid_next = 1'b1;
                to_cnt_next       = '0;
                state_next        = IDLE;
            end

            default: state_next = IDLE;
        endcase

        busy_next = (state_next == VEND) || (state_next == CHANGE);
    end

    assign led          = led_reg;
    assign credit_tens  = 4'(credit_reg / 7'd10);
    assign credit_ones  = 4'(credit_reg % 7'd10);
    assign dispense     = dispense_reg;
    assign change_valid = change_valid_reg;
    assign change       = change_reg;
    assign reject       = reject_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: instance u0 uses the default pricing,
// instance u1 a small credit ceiling with a short timeout.
module tb_vend_ctrl_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // instance 0: defaults, TICK_CYCLES=4
    logic       rst0 = 1'b1, coin_a0 = 1'b0, coin_b0 = 1'b0, cancel0 = 1'b0;
    logic [5:0] led0;
    logic [3:0] tens0, ones0;
    logic       dispense0, cv0, reject0, busy0;
    logic [6:0] change0;

    // instance 1: MAX_CREDIT=20, PRICE=99, TIMEOUT_TICKS=3, TICK_CYCLES=4
    logic       rst1 = 1'b1, coin_a1 = 1'b0, coin_b1 = 1'b0, cancel1 = 1'b0;
    logic [5:0] led1;
    logic [3:0] tens1, ones1;
    logic       dispense1, cv1, reject1, busy1;
    logic [6:0] change1;

    vend_ctrl_multi #(.TICK_CYCLES(4)) u0 (
        .clk(clk), .rst(rst0), .coin_a(coin_a0), .coin_b(coin_b0), .cancel(cancel0),
        .led(led0), .credit_tens(tens0), .credit_ones(ones0), .dispense(dispense0),
        .change_valid(cv0), .change(change0), .reject(reject0), .busy(busy0)
    );

    vend_ctrl_multi #(.TICK_CYCLES(4), .PRICE(99), .MAX_CREDIT(20), .TIMEOUT_TICKS(3)) u1 (
        .clk(clk), .rst(rst1), .coin_a(coin_a1), .coin_b(coin_b1), .cancel(cancel1),
        .led(led1), .credit_tens(tens1), .credit_ones(ones1), .dispense(dispense1),
        .change_valid(cv1), .change(change1), .reject(reject1), .busy(busy1)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int  lat;
        bit  seen;
        bit  cv_seen;
        bit  disp_seen;

        step(); step();
        rst0 = 1'b0; rst1 = 1'b0;
        step();
        chk("rst_led", 32'(led0), 0);
        chk("rst_credit", 32'({tens0, ones0}), 0);
        chk("rst_change", 32'(change0), 0);
        chk("rst_pulses", 32'({dispense0, cv0, reject0, busy0}), 0);
        $display("reset: led=%b credit=%0d%0d", led0, tens0, ones0);

        // basic sale: 10 + 10 + 5 = 25, exact price
        coin_b0 = 1'b1; step(); coin_b0 = 1'b0;
        chk("t1_credit10", 32'({tens0, ones0}), 32'h10);
        coin_b0 = 1'b1; step(); coin_b0 = 1'b0;
        chk("t1_credit20", 32'({tens0, ones0}), 32'h20);
        coin_a0 = 1'b1; step(); coin_a0 = 1'b0;
        chk("t1_credit25", 32'({tens0, ones0}), 32'h25);
        chk("t1_no_disp_yet", 32'(dispense0), 0);
        step();
        chk("t1_dispense", 32'(dispense0), 1);
        chk("t1_busy", 32'(busy0), 1);
        chk("t1_credit0", 32'({tens0, ones0}), 32'h00);
        chk("t1_led_first", 32'(led0), 32'h01);
        $display("sale: dispense=%b busy=%b led=%b", dispense0, busy0, led0);
        for (int i = 1; i < 24; i++) begin
            step();
            chk("t1_vend_led", 32'(led0), 32'(6'd1 << (i / 4)));
        end
        step();
        chk("t1_idle_led", 32'(led0), 0);
        chk("t1_idle_busy", 32'(busy0), 0);
        chk("t1_no_change", 32'(cv0), 0);
        $display("sale done: led=%b change_valid=%b", led0, cv0);

        // overpay 30 for price 25, coin during VEND is bounced
        coin_b0 = 1'b1; step(); step(); step(); coin_b0 = 1'b0;
        chk("t2_credit30", 32'({tens0, ones0}), 32'h30);
        step();
        chk("t2_dispense", 32'(dispense0), 1);
        chk("t2_credit5", 32'({tens0, ones0}), 32'h05);
        for (int i = 1; i < 24; i++) begin
            if (i == 10) coin_a0 = 1'b1;
            step();
            coin_a0 = 1'b0;
            chk("t2_vend_led", 32'(led0), 32'(6'd1 << (i / 4)));
            if (i == 10) begin
                chk("t2_busy_reject", 32'(reject0), 1);
                chk("t2_busy_credit", 32'({tens0, ones0}), 32'h05);
                $display("coin during vend: reject=%b credit=%0d%0d", reject0, tens0, ones0);
            end
        end
        step();
        chk("t2_change_msb", 32'(led0), 32'h20);
        chk("t2_change_busy", 32'(busy0), 1);
        for (int j = 1; j < 24; j++) begin
            step();
            chk("t2_change_led", 32'(led0), 32'(6'h20 >> (j / 4)));
            chk("t2_no_early_cv", 32'(cv0), 0);
        end
        step();
        chk("t2_cv", 32'(cv0), 1);
        chk("t2_change", 32'(change0), 5);
        chk("t2_credit_clear", 32'({tens0, ones0}), 0);
        chk("t2_led_off", 32'(led0), 0);
        $display("overpay: change_valid=%b change=%0d", cv0, change0);
        step();
        chk("t2_cv_pulse", 32'(cv0), 0);
        chk("t2_change_hold", 32'(change0), 5);

        // both coins in one cycle, then cancel with a coin
        coin_a0 = 1'b1; coin_b0 = 1'b1; step(); coin_a0 = 1'b0; coin_b0 = 1'b0;
        chk("t4_both_coins", 32'({tens0, ones0}), 32'h15);
        cancel0 = 1'b1; coin_a0 = 1'b1; step(); cancel0 = 1'b0; coin_a0 = 1'b0;
        chk("t4_cancel_reject", 32'(reject0), 1);
        chk("t4_refund_credit", 32'({tens0, ones0}), 32'h15);
        step();
        chk("t4_refund_cv", 32'(cv0), 1);
        chk("t4_refund_change", 32'(change0), 15);
        chk("t4_refund_credit0", 32'({tens0, ones0}), 0);
        $display("cancel: change_valid=%b change=%0d", cv0, change0);
        step();
        cancel0 = 1'b1; step(); cancel0 = 1'b0;
        chk("t4_cancel0_quiet", 32'({reject0, cv0, busy0}), 0);
        step();
        chk("t4_cancel0_no_cv", 32'(cv0), 0);
        chk("t4_cancel0_change", 32'(change0), 15);
        $display("cancel at zero: change_valid=%b", cv0);

        // saturation on instance 1
        coin_b1 = 1'b1; step(); step(); coin_b1 = 1'b0;
        chk("t3_credit20", 32'({tens1, ones1}), 32'h20);
        coin_a1 = 1'b1; step(); coin_a1 = 1'b0;
        chk("t3_sat_reject", 32'(reject1), 1);
        chk("t3_sat_credit", 32'({tens1, ones1}), 32'h20);
        step();
        chk("t3_reject_pulse", 32'(reject1), 0);
        $display("saturation: credit=%0d%0d", tens1, ones1);

        // timeout on instance 1
        rst1 = 1'b1; step(); rst1 = 1'b0; step();
        coin_a1 = 1'b1; step(); coin_a1 = 1'b0;
        chk("t5_credit5", 32'({tens1, ones1}), 32'h05);
        seen = 0; lat = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (cv1) begin seen = 1; lat = k; end
        end
        chk("t5_to_seen", 32'(seen), 1);
        chk("t5_to_window", 32'(lat >= 10 && lat <= 13), 1);
        chk("t5_to_change", 32'(change1), 5);
        chk("t5_to_credit0", 32'({tens1, ones1}), 0);
        $display("timeout: latency=%0d change=%0d", lat, change1);

        // timeout restart: a second coin resets the idle count
        coin_a1 = 1'b1; step(); coin_a1 = 1'b0;
        repeat (6) step();
        coin_a1 = 1'b1; step(); coin_a1 = 1'b0;
        chk("t5_credit10", 32'({tens1, ones1}), 32'h10);
        seen = 0; lat = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            step();
            if (cv1) begin seen = 1; lat = k; end
        end
        chk("t5_rs_seen", 32'(seen), 1);
        chk("t5_rs_window", 32'(lat >= 10 && lat <= 13), 1);
        chk("t5_rs_change", 32'(change1), 10);
        $display("timeout restart: latency=%0d change=%0d", lat, change1);

        // reset during CHANGE sweep
        coin_b0 = 1'b1; step(); step(); step(); coin_b0 = 1'b0;
        step();
        chk("t6_dispense", 32'(dispense0), 1);
        repeat (24) step();
        chk("t6_in_change", 32'(led0), 32'h20);
        repeat (5) step();
        rst0 = 1'b1;
        #1;
        chk("t6_rst_led", 32'(led0), 0);
        chk("t6_rst_credit", 32'({tens0, ones0}), 0);
        chk("t6_rst_busy", 32'(busy0), 0);
        chk("t6_rst_change", 32'(change0), 0);
        step();
        rst0 = 1'b0;
        cv_seen = 0; disp_seen = 0;
        repeat (40) begin
            step();
            if (cv0) cv_seen = 1;
            if (dispense0) disp_seen = 1;
        end
        chk("t6_no_cv", 32'(cv_seen), 0);
        chk("t6_no_disp", 32'(disp_seen), 0);
        chk("t6_led_idle", 32'(led0), 0);
        $display("reset mid-change: led=%b credit=%0d%0d", led0, tens0, ones0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
